uart_rx_fifo: RTL and testbench

Parametrised, oversampling UART receiver with an output FIFO, sitting between the board-level `FPGA_SERIAL_RX` pin and the MIPS150 memory-mapped UART registers. It is the next generation of the processor's serial receive path. It adds configurable baud, data width, oversample ratio, FIFO depth and optional parity. It also adds majority-vote sampling and framing, parity and overrun reporting. The CPU side drains received words through a ready/valid handshake.

---
 rtl/uart_rx_fifo.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver (2-of-3 majority per bit) feeding a first-word-fall-through FIFO.
// Define UART_RX_PARITY_EN to build the parity stage; PARITY_ODD then selects odd/even sense.
module uart_rx_fifo #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 FPGA_SERIAL_RX,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_out_valid,
    input  logic                 data_out_ready,
    output logic                 frame_error,
    output logic                 parity_error,
    output logic                 overrun
);

    localparam int TICK_RAW = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int TICK_DIV = (TICK_RAW < 1) ? 1 : TICK_RAW;
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW       = $clog2(OVERSAMPLE);
    localparam int BW       = $clog2(DATA_BITS);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int PW       = AW + 1;

    localparam logic [SW-1:0] SAMP_A = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMP_B = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] SAMP_C = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY    = 3'd3;
`endif
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_HIGH = 3'd5;

    logic                 rx_meta, rx_sync, rx_prev;
    logic                 fall, start_edge;
    logic [TW-1:0]        tick_cnt;
    logic                 tick;
    logic [SW-1:0]        samp_cnt;
    logic [1:0]           votes;
    logic                 maj, resolve;
    logic [2:0]           state;
    logic [DATA_BITS-1:0] shreg;
    logic [BW-1:0]        bit_cnt;
    logic                 par_bad;
    logic                 stop_ok, stop_bad, push;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic                 empty, full, pop, wr_en;

    // Synchroniser plus one history flop for falling-edge detection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= FPGA_SERIAL_RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall       = rx_prev & ~rx_sync;
    assign start_edge = (state == S_IDLE) && fall;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (!rst || start_edge)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    // Sample counter runs free modulo OVERSAMPLE from the start edge; every
    // bit is decided at SAMP_C, so the next decision is exactly one bit later.
    always_ff @(posedge clk) begin
        if (!rst || start_edge) begin
            samp_cnt <= '0;
            votes    <= 2'b00;
        end else if (tick) begin
            samp_cnt <= (samp_cnt == SAMP_LAST) ? '0 : samp_cnt + 1'b1;
            if (samp_cnt == SAMP_A)
                votes[0] <= rx_sync;
            if (samp_cnt == SAMP_B)
                votes[1] <= rx_sync;
        end
    end

    assign resolve = tick && (samp_cnt == SAMP_C);
    assign maj     = (votes[0] & votes[1]) | (votes[0] & rx_sync) | (votes[1] & rx_sync);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fall)
                        state <= S_START;
                end
                S_START: begin
                    if (resolve) begin
                        state   <= maj ? S_IDLE : S_DATA;
                        bit_cnt <= '0;
                    end
                end
                S_DATA: begin
                    if (resolve) begin
                        shreg   <= {maj, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST)
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (resolve)
                        state <= S_STOP;
                end
`endif
                S_STOP: begin
                    if (resolve)
                        state <= maj ? S_IDLE : S_WAIT_HIGH;
                end
                S_WAIT_HIGH: begin
                    if (rx_sync)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    // Mismatch is latched at the parity bit and consumed at the stop bit.
    always_ff @(posedge clk) begin
        if (!rst || start_edge)
            par_bad <= 1'b0;
        else if (state == S_PARITY && resolve)
            par_bad <= maj ^ (^shreg) ^ PARITY_ODD;
    end
`else
    assign par_bad = 1'b0;
`endif

    assign stop_ok  = resolve && (state == S_STOP) && maj;
    assign stop_bad = resolve && (state == S_STOP) && !maj;
    assign push     = stop_ok && !par_bad;

    assign empty          = (wr_ptr == rd_ptr);
    assign full           = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign data_out_valid = !empty;
    assign pop            = data_out_valid && data_out_ready;
    assign wr_en          = push && (!full || pop);

    // When full with a pop, the write lands in the slot being vacated.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= shreg;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    assign data_out = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_error <= stop_bad;
            overrun     <= push && full && !pop;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst)
            parity_error <= 1'b0;
        else
            parity_error <= stop_ok && par_bad;
    end
`else
    assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed + randomized bench for uart_rx_fifo; expectations come from a frame-level
// model (word queue, occupancy count, flag counters) driven by what the bench transmits.
module tb_uart_rx_fifo;

    localparam int CF     = 1_843_200;
    localparam int BR     = 115_200;
    localparam int DB     = 8;
    localparam int OS     = 16;
    localparam int FD     = 4;
    localparam int BITCLK = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PODD   = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx = 1'b1;
    logic          ready = 1'b0;
    logic [DB-1:0] data_out;
    logic          data_out_valid;
    logic          frame_error, parity_error, overrun;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLOCK_FREQ(CF),
        .BAUD_RATE (BR),
        .DATA_BITS (DB),
        .OVERSAMPLE(OS),
        .FIFO_DEPTH(FD)
`ifdef UART_RX_PARITY_EN
        ,
        .PARITY_ODD(PODD)
`endif
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .FPGA_SERIAL_RX(rx),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(ready),
        .frame_error   (frame_error),
        .parity_error  (parity_error),
        .overrun       (overrun)
    );

    int compared = 0;
    int mismatched = 0;

    // Observed behaviour, sampled 1 time unit after each falling edge.
    int            fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, vld_cyc = 0, stab_err = 0;
    logic [DB-1:0] rcvq[$];
    logic          prev_hold = 1'b0;
    logic [DB-1:0] prev_data = '0;

    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            if (frame_error)  fe_cnt++;
            if (parity_error) pe_cnt++;
            if (overrun)      ov_cnt++;
            if (data_out_valid) vld_cyc++;
            if (prev_hold && (!data_out_valid || data_out !== prev_data)) stab_err++;
            if (data_out_valid && ready) rcvq.push_back(data_out);
            prev_hold = data_out_valid && !ready;
            prev_data = data_out;
        end else begin
            prev_hold = 1'b0;
        end
    end

    // Reference model: what the consumer should see, per transmitted frame.
    logic [DB-1:0] expq[$];
    int            exp_fe = 0, exp_pe = 0, exp_ov = 0;
    int            mocc = 0;
    bit            holding = 1'b0;

    task automatic model_frame(input logic [DB-1:0] d, input bit good_stop, input bit good_par);
        if (!good_stop)            exp_fe++;
        else if (!good_par)        exp_pe++;
        else if (holding && mocc == FD) exp_ov++;
        else begin
            expq.push_back(d);
            if (holding) mocc++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        logic [31:0] got;
        check({tag, " words"}, rcvq.size(), expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            got = (i < rcvq.size()) ? 32'(rcvq[i]) : 'x;
            check($sformatf("%s word%0d", tag, i), got, 32'(expq[i]));
        end
        check({tag, " frame_error"},  fe_cnt, exp_fe);
        check({tag, " parity_error"}, pe_cnt, exp_pe);
        check({tag, " overrun"},      ov_cnt, exp_ov);
        check({tag, " stable"},       stab_err, 0);
        rcvq.delete();
        expq.delete();
    endtask

    task automatic hold(input logic v, input int n);
        repeat (n) begin
            rx = v;
            @(negedge clk);
        end
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        for (int c = 0; c < BITCLK; c++) begin
            rx = (glitch && c == 8) ? ~b : b;
            @(negedge clk);
        end
    endtask

    task automatic send(input logic [DB-1:0] d, input int stop_low, input bit glitch, input bit par_flip);
        hold(1'b0, BITCLK);
        for (int i = 0; i < DB; i++) send_bit(d[i], glitch);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ PODD ^ par_flip, 1'b0);
`else
        if (par_flip) hold(1'b1, 0);
`endif
        if (stop_low > 0) hold(1'b0, stop_low * BITCLK);
        hold(1'b1, BITCLK);
    endtask

    task automatic drain(input string tag);
        int budget = 400;
        while (data_out_valid && budget > 0) begin
            ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            budget--;
        end
        ready = 1'b0;
        check({tag, " drained"}, 32'(data_out_valid), 32'd0);
        mocc = 0;
    endtask

    initial begin
        logic [DB-1:0] d;
        int            n;

        // Reset state over five held cycles.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("rst data_out", 32'(data_out), 32'd0);
            check("rst valid",    32'(data_out_valid), 32'd0);
            check("rst frame",    32'(frame_error), 32'd0);
            check("rst parity",   32'(parity_error), 32'd0);
            check("rst overrun",  32'(overrun), 32'd0);
        end
        rst = 1'b1;
        hold(1'b1, 20);

        // Single word, consumer always ready: valid for exactly one cycle.
        ready = 1'b1;
        vld_cyc = 0;
        send(8'h55, 0, 1'b0, 1'b0);
        model_frame(8'h55, 1'b1, 1'b1);
        hold(1'b1, 40);
        check("single valid cycles", vld_cyc, 1);
        compare_all("single");

        // Five back-to-back frames with the consumer stalled.
        ready = 1'b0;
        holding = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            send(DB'(i), 0, 1'b0, 1'b0);
            model_frame(DB'(i), 1'b1, 1'b1);
        end
        hold(1'b1, 20);
        check("ovr head valid", 32'(data_out_valid), 32'd1);
        check("ovr head data",  32'(data_out), 32'(expq[0]));
        drain("ovr");
        holding = 1'b0;
        hold(1'b1, 4);
        compare_all("ovr");

        // Stop bit held low (break), then recovery.
        ready = 1'b1;
        send(8'hA3, 3, 1'b0, 1'b0);
        model_frame(8'hA3, 1'b0, 1'b1);
        hold(1'b1, 32);
        send(8'h3C, 0, 1'b0, 1'b0);
        model_frame(8'h3C, 1'b1, 1'b1);
        hold(1'b1, 30);
        compare_all("frame");

        // Short glitch on idle line is a false start; single-sample upsets are voted out.
        hold(1'b0, 4);
        hold(1'b1, 40);
        compare_all("glitch idle");
        send(8'hF0, 0, 1'b1, 1'b0);
        model_frame(8'hF0, 1'b1, 1'b1);
        hold(1'b1, 30);
        compare_all("glitch vote");

`ifdef UART_RX_PARITY_EN
        send(8'h07, 0, 1'b0, 1'b0);
        model_frame(8'h07, 1'b1, 1'b1);
        hold(1'b1, 20);
        send(8'h07, 0, 1'b0, 1'b1);
        model_frame(8'h07, 1'b1, 1'b0);
        hold(1'b1, 30);
        compare_all("parity");
`endif

        // Reset during data bit 4 of 0x99 abandons the frame silently.
        hold(1'b0, BITCLK);
        for (int i = 0; i < 4; i++) send_bit(1'(8'h99 >> i), 1'b0);
        hold(1'b1, 5);
        rst = 1'b0;
        hold(1'b1, 2);
        rst = 1'b1;
        hold(1'b1, 48);
        send(8'h66, 0, 1'b0, 1'b0);
        model_frame(8'h66, 1'b1, 1'b1);
        hold(1'b1, 30);
        compare_all("mid reset");

        // Random stream with random gaps, consumer always ready.
        for (int i = 0; i < 10; i++) begin
            d = DB'($urandom);
            send(d, 0, 1'($urandom_range(0, 1)), 1'b0);
            model_frame(d, 1'b1, 1'b1);
            hold(1'b1, $urandom_range(0, 24));
        end
        hold(1'b1, 30);
        compare_all("rand stream");

        // Random burst into a stalled consumer, then random-ready drain.
        ready = 1'b0;
        holding = 1'b1;
        n = $urandom_range(2, 7);
        for (int i = 0; i < n; i++) begin
            d = DB'($urandom);
            send(d, 0, 1'b0, 1'b0);
            model_frame(d, 1'b1, 1'b1);
        end
        hold(1'b1, 20);
        drain("rand burst");
        holding = 1'b0;
        hold(1'b1, 4);
        compare_all("rand burst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
